// File: rtl/rx_pkg.sv
// rx_pkg: shared definitions for the Rx frame checker slice.
//  - rx_state_t: frame checker FSM state encoding.
//  - PARITY_EVEN / PARITY_ODD: parity sense selectors.
//  - entry_width / *_ofs helpers: FIFO entry layout {framing_err, parity_err, data}.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_PARITY = 2'd1,
    ST_WAIT_STOP   = 2'd2,
    ST_COMMIT      = 2'd3
  } rx_state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Data occupies the low bits of an entry; the two error flags sit above it.
  localparam int DATA_OFS = 0;

  function automatic int entry_width(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int perr_ofs(input int data_width);
    return data_width;
  endfunction

  function automatic int ferr_ofs(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: single-clock FIFO holding checked Rx frames.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   push, push_data write request and entry
//   pop             read request (ignored while empty)
//   overflow_clear  clears the sticky overflow flag
//   pop_data        registered head entry (0 after reset)
//   full, empty     occupancy status
//   count           occupied entries, 0..DEPTH
//   overflow        sticky: a push was dropped because the FIFO was full
// A push while full is still accepted when a pop happens in the same cycle.
module rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     overflow_clear,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             overflow_q;

  logic pop_en;
  logic push_en;
  logic overflow_set;

  assign empty        = (count_q == '0);
  assign full         = (count_q == (AW+1)'(DEPTH));
  assign pop_en       = pop & ~empty;
  assign push_en      = push & (~full | pop_en);
  assign overflow_set = push & full & ~pop_en;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_en && !pop_en) begin
        count_q <= count_q + 1'b1;
      end else if (pop_en && !push_en) begin
        count_q <= count_q - 1'b1;
      end
      // A set event in the same cycle as a clear takes priority.
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end else if (overflow_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: back-end of the UART receiver. Latches the deserialized
// byte on a rising edge of data_is_valid, captures the parity and stop bits
// on the deserializer's sampling strobes, checks them and queues
// {framing_err, parity_err, data} in rx_sync_fifo.
// Build option: define RX_PARITY_CHECK_EN to check parity; otherwise the
// parity bit is still consumed but parity_err is always 0.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   serial_in_synced           Rx line, sampled for the parity and stop bits
//   sampling_strobe            one-cycle bit-centre pulse
//   is_parity_stage            high while the parity bit is on the line
//   data_is_valid              all data bits sampled (rising edge used)
//   received_data              deserialized byte
//   overflow_clear             clears the sticky overflow flag
//   rx_data, rx_parity_error,
//   rx_framing_error           head entry of the FIFO
//   rx_valid / rx_ready        consumer handshake
//   overflow                   sticky frame-dropped flag
//   fifo_count                 occupied FIFO entries
//   debug_state                current FSM state (rx_state_t encoding)
// Handshake: the head entry is offered while rx_valid is high and is held
// stable until the cycle in which rx_valid and rx_ready are both high; that
// cycle pops it and the next entry (or rx_valid low) appears one cycle later.
module rx_frame_checker
  import rx_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int PARITY_ODD       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in_synced,
  input  logic                          sampling_strobe,
  input  logic                          is_parity_stage,
  input  logic                          data_is_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]   received_data,
  input  logic                          overflow_clear,
  output logic [INPUT_DATA_WIDTH-1:0]   rx_data,
  output logic                          rx_parity_error,
  output logic                          rx_framing_error,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    debug_state
);

  localparam int EW       = entry_width(INPUT_DATA_WIDTH);
  localparam int PERR_BIT = perr_ofs(INPUT_DATA_WIDTH);
  localparam int FERR_BIT = ferr_ofs(INPUT_DATA_WIDTH);

  rx_state_t                   state;
  logic                        dv_q;
  logic                        dv_rise_q;
  logic [INPUT_DATA_WIDTH-1:0] data_q;
  logic                        stop_q;
  logic                        parity_err;
  logic                        framing_err;
  logic                        push;
  logic [EW-1:0]               push_entry;
  logic [EW-1:0]               head_entry;
  logic                        fifo_empty;
  logic                        fifo_full;

`ifdef RX_PARITY_CHECK_EN
  logic parity_q;
  assign parity_err = (^data_q) ^ parity_q ^ (PARITY_ODD != 0);
`else
  assign parity_err = 1'b0;
`endif

  assign framing_err = ~stop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dv_q      <= 1'b0;
      dv_rise_q <= 1'b0;
      data_q    <= '0;
      stop_q    <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // Registered edge detect: the byte is captured one cycle after
      // data_is_valid rises, from the value present in that cycle.
      dv_q      <= data_is_valid;
      dv_rise_q <= data_is_valid & ~dv_q;
      // A new byte restarts frame assembly from any waiting state; COMMIT
      // always completes in its single cycle.
      if (dv_rise_q && state != ST_COMMIT) begin
        data_q <= received_data;
        state  <= ST_WAIT_PARITY;
      end else begin
        case (state)
          ST_WAIT_PARITY: begin
            if (sampling_strobe && is_parity_stage) begin
`ifdef RX_PARITY_CHECK_EN
              parity_q <= serial_in_synced;
`endif
              state <= ST_WAIT_STOP;
            end
          end
          ST_WAIT_STOP: begin
            if (sampling_strobe && !is_parity_stage) begin
              stop_q <= serial_in_synced;
              state  <= ST_COMMIT;
            end
          end
          ST_COMMIT: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  assign push = (state == ST_COMMIT);

  always_comb begin
    push_entry                                 = '0;
    push_entry[DATA_OFS +: INPUT_DATA_WIDTH]   = data_q;
    push_entry[PERR_BIT]                       = parity_err;
    push_entry[FERR_BIT]                       = framing_err;
  end

  rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_data      (push_entry),
    .pop            (rx_ready),
    .overflow_clear (overflow_clear),
    .pop_data       (head_entry),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .count          (fifo_count),
    .overflow       (overflow)
  );

  assign rx_data          = head_entry[DATA_OFS +: INPUT_DATA_WIDTH];
  assign rx_parity_error  = head_entry[PERR_BIT];
  assign rx_framing_error = head_entry[FERR_BIT];
  assign rx_valid         = ~fifo_empty;
  assign debug_state      = state;

endmodule
